// File: rtl/img_stream_encode_if.sv
// rtl/img_stream_encode_if.sv - frame request, pixel input and byte output bundle for img_stream_encode
//
// Signals:
//   start        frame request (sampled by the encoder only while idle)
//   width/height frame size in pixels, sampled together with start
//   pixel_in     upstream pixel byte, qualified by pixel_valid
//   pixel_ready  encoder takes pixel_in on this cycle's rising edge
//   data_out     encoded byte, qualified by data_valid
//   out_ready    downstream takes data_out on this cycle's rising edge
//   busy         frame in progress
//   done         one-cycle end-of-frame pulse
// Modports: master = encoder side, slave = frame source / byte sink side.

interface img_stream_encode_if;
  logic        start;
  logic [15:0] width;
  logic [15:0] height;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  modport master (
    input  start, width, height, pixel_in, pixel_valid, out_ready,
    output pixel_ready, data_out, data_valid, busy, done
  );

  modport slave (
    output start, width, height, pixel_in, pixel_valid, out_ready,
    input  pixel_ready, data_out, data_valid, busy, done
  );
endinterface

// File: rtl/img_stream_encode.sv
// rtl/img_stream_encode.sv - frame encoder: 6-byte header followed by width*height pixel bytes
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    img_stream_encode_if.master (start/width/height request, pixel input
//          handshake, registered byte output handshake, busy/done status)
//
// Stream layout: MAGIC0, MAGIC1, width[15:8], width[7:0], height[15:8], height[7:0],
// then the pixels in arrival order.

module img_stream_encode #(
  parameter logic [7:0] MAGIC0 = 8'hA5,
  parameter logic [7:0] MAGIC1 = 8'h5A
) (
  input  logic                clk,
  input  logic                reset,
  img_stream_encode_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_PIX   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_n;

  logic [15:0] width_q;
  logic [15:0] height_q;
  logic [31:0] remaining;
  logic [2:0]  idx;
  logic [7:0]  data_q;
  logic        valid_q;

  logic        free;
  logic        pix_take;
  logic [7:0]  hdr_byte;

  // The output register can take a new byte when it is empty or its byte
  // leaves on this edge.
  assign free     = !valid_q || bus.out_ready;
  assign pix_take = (state == S_PIX) && free && bus.pixel_valid;

  always_comb begin
    hdr_byte = MAGIC0;
    case (idx)
      3'd0:    hdr_byte = MAGIC0;
      3'd1:    hdr_byte = MAGIC1;
      3'd2:    hdr_byte = width_q[15:8];
      3'd3:    hdr_byte = width_q[7:0];
      3'd4:    hdr_byte = height_q[15:8];
      3'd5:    hdr_byte = height_q[7:0];
      default: hdr_byte = MAGIC0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (bus.start) state_n = S_HDR;
      end
      S_HDR: begin
        // Zero-sized frames skip PIX entirely and never raise pixel_ready.
        if (free && idx == 3'd5) state_n = (remaining != 32'd0) ? S_PIX : S_DRAIN;
      end
      S_PIX: begin
        if (pix_take && remaining == 32'd1) state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (free) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      width_q   <= 16'd0;
      height_q  <= 16'd0;
      remaining <= 32'd0;
      idx       <= 3'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            width_q   <= bus.width;
            height_q  <= bus.height;
            // Zero-extended to 32 bits so 65535*65535 cannot wrap.
            remaining <= {16'd0, bus.width} * {16'd0, bus.height};
            idx       <= 3'd0;
          end
        end
        S_HDR: begin
          if (free) begin
            data_q  <= hdr_byte;
            valid_q <= 1'b1;
            idx     <= idx + 3'd1;
          end
        end
        S_PIX: begin
          if (pix_take) begin
            data_q    <= bus.pixel_in;
            valid_q   <= 1'b1;
            remaining <= remaining - 32'd1;
          end else if (free) begin
            // Upstream starved: emit a bubble rather than repeat the last byte.
            valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (free) valid_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pixel_ready = (state == S_PIX) && free;
  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = (state == S_DONE);

endmodule

// File: tb/tb_img_stream_encode.sv
// tb/tb_img_stream_encode.sv - self-checking bench for img_stream_encode

module tb_img_stream_encode;

  logic clk = 1'b0;
  logic reset = 1'b0;

  img_stream_encode_if bus ();

  img_stream_encode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Written only by the monitor.
  logic [7:0] rx_q[$];
  int         xfer_q[$];
  int         done_q[$];
  int         cyc_ctr = 0;
  int         take_cnt = 0;
  int         pr_cnt = 0;

  // Written only by the main sequence.
  logic [7:0] pix_arr[$];
  int         frame_id = 0;
  int         gap_cfg = 0;
  bit         rand_pv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge what will transfer on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc_ctr++;
      if (reset) begin
        if (bus.data_valid && bus.out_ready) begin
          rx_q.push_back(bus.data_out);
          xfer_q.push_back(cyc_ctr);
        end
        if (bus.done) done_q.push_back(cyc_ctr);
        if (bus.pixel_ready) pr_cnt++;
        if (bus.pixel_valid && bus.pixel_ready) take_cnt++;
      end
    end
  end

  // Pixel source: presents pix_arr in order, optional gap after each accepted pixel.
  initial begin
    int seen_id;
    int pix_idx;
    int last_take;
    int gap_left;
    seen_id = 0;
    pix_idx = 0;
    last_take = 0;
    gap_left = 0;
    bus.pixel_valid = 1'b0;
    bus.pixel_in = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (frame_id != seen_id) begin
        seen_id = frame_id;
        pix_idx = 0;
        last_take = take_cnt;
        gap_left = 0;
      end else if (take_cnt != last_take) begin
        pix_idx += take_cnt - last_take;
        last_take = take_cnt;
        gap_left = gap_cfg;
      end
      if (gap_left > 0) begin
        bus.pixel_valid = 1'b0;
        gap_left--;
      end else if (pix_idx < pix_arr.size()) begin
        bus.pixel_in = pix_arr[pix_idx];
        bus.pixel_valid = rand_pv ? 1'($urandom_range(0, 1)) : 1'b1;
      end else begin
        bus.pixel_valid = 1'b0;
      end
    end
  end

  task automatic run_frame(input string tag, input int w, input int h, input bit fixed,
                           input bit rnd_or, input bit rnd_pv, input int gap,
                           input bit bp, input bit inj);
    logic [7:0] exp_q[$];
    int p, rb, db, pb, cyc, budget, bp_left, n, span;
    bit bp_hit, clean;
    p = w * h;
    clean = !rnd_or && !rnd_pv && (gap == 0) && !bp;
    pix_arr.delete();
    for (int i = 0; i < p; i++) begin
      if (fixed) pix_arr.push_back(8'((i + 1) * 8'h11));
      else pix_arr.push_back(8'($urandom_range(0, 255)));
    end
    // Reference stream: big-endian header followed by the pixels in order.
    exp_q = {8'hA5, 8'h5A, 8'(w >> 8), 8'(w), 8'(h >> 8), 8'(h)};
    foreach (pix_arr[i]) exp_q.push_back(pix_arr[i]);
    gap_cfg = gap;
    rand_pv = rnd_pv;
    frame_id++;
    rb = rx_q.size();
    db = done_q.size();
    pb = pr_cnt;
    budget = 20 * (6 + p) + 50 + 6 * gap * p;

    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.width = 16'(w);
    bus.height = 16'(h);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_after_start"}, 32'(bus.busy), 32'd1);

    cyc = 0;
    bp_left = 0;
    bp_hit = 1'b0;
    while (done_q.size() == db && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (inj && cyc == 10) begin
        bus.start = 1'b1;
        bus.width = 16'd7;
        bus.height = 16'd9;
      end else if (inj && cyc == 11) begin
        bus.start = 1'b0;
      end
      if (bp && !bp_hit && bus.data_valid && (rx_q.size() - rb) == 2) begin
        bp_hit = 1'b1;
        bp_left = 3;
      end
      if (bp_left > 0) begin
        bus.out_ready = 1'b0;
        bp_left--;
        chk({tag, "_bp_data"}, 32'(bus.data_out), 32'h00);
        chk({tag, "_bp_valid"}, 32'(bus.data_valid), 32'd1);
      end else begin
        bus.out_ready = rnd_or ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    chk({tag, "_no_timeout"}, 32'(cyc < budget), 32'd1);
    // Loop exits just after the DONE -> IDLE edge.
    chk({tag, "_idle_after_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done_low"}, 32'(bus.done), 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_single_done"}, 32'(done_q.size() - db), 32'd1);
    chk({tag, "_stays_idle"}, 32'(bus.busy), 32'd0);
    if (bp) chk({tag, "_bp_seen"}, 32'(bp_hit), 32'd1);

    n = rx_q.size() - rb;
    chk({tag, "_len"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[rb + i]), 32'(exp_q[i]));
    end
    if (n > 0) begin
      span = xfer_q[rb + n - 1] - xfer_q[rb];
      chk({tag, "_done_timing"}, 32'(done_q[db]), 32'(xfer_q[rb + n - 1] + 1));
      if (clean) chk({tag, "_contiguous"}, 32'(span), 32'(exp_q.size() - 1));
      if (gap > 0) chk({tag, "_bubbles"}, 32'(span > exp_q.size() - 1), 32'd1);
    end
    if (p == 0) chk({tag, "_no_pixel_ready"}, 32'(pr_cnt - pb), 32'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.width = 16'd0;
    bus.height = 16'd0;
    bus.out_ready = 1'b1;

    @(negedge clk);
    chk("rst_data_out", 32'(bus.data_out), 32'h00);
    chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_pixel_ready", 32'(bus.pixel_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    run_frame("f2x2", 2, 2, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_frame("bp2x2", 2, 2, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_frame("zero0x5", 0, 5, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_frame("starve1x3", 1, 3, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b0);
    run_frame("inject3x4", 3, 4, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Abandon a 4x4 frame mid-pixels with an asynchronous reset.
    pix_arr.delete();
    for (int i = 0; i < 16; i++) pix_arr.push_back(8'($urandom_range(0, 255)));
    gap_cfg = 0;
    rand_pv = 1'b0;
    frame_id++;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.width = 16'd4;
    bus.height = 16'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_data_out", 32'(bus.data_out), 32'h00);
    chk("arst_data_valid", 32'(bus.data_valid), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_pixel_ready", 32'(bus.pixel_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_frame("post_rst1x1", 1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    run_frame("wide257x1", 257, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      run_frame($sformatf("rnd%0d", k), $urandom_range(0, 5), $urandom_range(0, 5),
                1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
